// File: rtl/sram_pixel_packer.sv
// sram_pixel_packer: packs an RGB888 pixel stream into 16-bit SRAM words,
// two pixels per three words, written linearly from START_ADDR.
//   word 3k = {R0,G0}, word 3k+1 = {B0,R1}, word 3k+2 = {G1,B1}
// Ports:
//   clk, reset (async, active-low)
//   start      one-cycle pulse, begins a frame
//   done       one-cycle pulse, the cycle after the final word is presented
//   pix_valid/pix_ready/r/g/b   pixel input handshake
//   raddr      read address, unused (tied to 0)
//   waddr/wdata/wr_enable       SRAM write client port, registered
// Optional build macro: SRAM_PIXEL_PACKER_BYTESWAP_EN swaps the bytes of every
// written word; addresses and timing are unaffected.
module sram_pixel_packer #(
  parameter int unsigned AW           = 18,
  parameter int unsigned DW           = 16,
  parameter int unsigned START_ADDR   = 115200,
  parameter int unsigned IMAGE_WIDTH  = 320,
  parameter int unsigned IMAGE_HEIGHT = 240
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          done,
  input  logic          pix_valid,
  output logic          pix_ready,
  input  logic [7:0]    r,
  input  logic [7:0]    g,
  input  logic [7:0]    b,
  output logic [AW-1:0] raddr,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  output logic          wr_enable
);

  localparam int unsigned NUM_PIX  = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int unsigned NUM_WORD = (3 * NUM_PIX) / 2;
  localparam int unsigned PCW      = $clog2(NUM_PIX + 1);
  localparam int unsigned WCW      = $clog2(NUM_WORD + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_EVEN  = 3'd1;
  localparam logic [2:0] S_ODD   = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]     state, state_nxt;
  logic [PCW-1:0] pix_cnt, pix_cnt_nxt;
  logic [WCW-1:0] word_idx, word_idx_nxt;
  logic [15:0]    hold, hold_nxt;
  logic [AW-1:0]  waddr_nxt;
  logic [DW-1:0]  wdata_nxt;
  logic           wr_enable_nxt, pix_ready_nxt, done_nxt;
  logic [15:0]    word;
  logic           do_write;
  logic           accept;

  // Final word formatting (optional byte swap)
  function automatic logic [15:0] pack_word(input logic [15:0] w);
`ifdef SRAM_PIXEL_PACKER_BYTESWAP_EN
    return {w[7:0], w[15:8]};
`else
    return w;
`endif
  endfunction

  assign raddr  = '0;
  assign accept = pix_valid & pix_ready;

  // Next-state and registered-output computation
  always_comb begin
    state_nxt     = state;
    pix_cnt_nxt   = pix_cnt;
    word_idx_nxt  = word_idx;
    hold_nxt      = hold;
    waddr_nxt     = waddr;
    wdata_nxt     = wdata;
    wr_enable_nxt = 1'b0;
    word          = 16'h0000;
    do_write      = 1'b0;

    case (state)
      S_IDLE: begin
        // A start coinciding with the trailing done pulse is ignored.
        if (start && !done) begin
          state_nxt    = S_EVEN;
          pix_cnt_nxt  = '0;
          word_idx_nxt = '0;
        end
      end
      S_EVEN: begin
        if (accept) begin
          word        = {r, g};
          do_write    = 1'b1;
          hold_nxt    = {8'h00, b};
          pix_cnt_nxt = pix_cnt + PCW'(1);
          state_nxt   = S_ODD;
        end
      end
      S_ODD: begin
        if (accept) begin
          word        = {hold[7:0], r};
          do_write    = 1'b1;
          hold_nxt    = {g, b};
          pix_cnt_nxt = pix_cnt + PCW'(1);
          state_nxt   = S_FLUSH;
        end
      end
      S_FLUSH: begin
        word      = hold;
        do_write  = 1'b1;
        state_nxt = (pix_cnt == PCW'(NUM_PIX)) ? S_DONE : S_EVEN;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    if (do_write) begin
      wr_enable_nxt = 1'b1;
      wdata_nxt     = DW'(pack_word(word));
      waddr_nxt     = AW'(START_ADDR) + AW'(word_idx);
      word_idx_nxt  = word_idx + WCW'(1);
    end

    pix_ready_nxt = (state_nxt == S_EVEN) || (state_nxt == S_ODD);
    // done trails the DONE state by one cycle, i.e. follows the last write.
    done_nxt      = (state == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      pix_cnt   <= '0;
      word_idx  <= '0;
      hold      <= '0;
      waddr     <= '0;
      wdata     <= '0;
      wr_enable <= 1'b0;
      pix_ready <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      pix_cnt   <= pix_cnt_nxt;
      word_idx  <= word_idx_nxt;
      hold      <= hold_nxt;
      waddr     <= waddr_nxt;
      wdata     <= wdata_nxt;
      wr_enable <= wr_enable_nxt;
      pix_ready <= pix_ready_nxt;
      done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_sram_pixel_packer.sv
// Self-checking bench for sram_pixel_packer: two instances, a 2x1 frame at
// START_ADDR=100 (vector table) and a 4x2 frame at the default START_ADDR
// (gaps, stray start, mid-frame reset).
module tb_sram_pixel_packer;

  logic        clk;
  logic        reset;

  logic        start_a, pv_a, done_a, ready_a, we_a;
  logic [7:0]  r_a, g_a, b_a;
  logic [17:0] raddr_a, waddr_a;
  logic [15:0] wdata_a;

  logic        start_b, pv_b, done_b, ready_b, we_b;
  logic [7:0]  r_b, g_b, b_b;
  logic [17:0] raddr_b, waddr_b;
  logic [15:0] wdata_b;

  int checks = 0;
  int errors = 0;

  sram_pixel_packer #(.START_ADDR(100), .IMAGE_WIDTH(2), .IMAGE_HEIGHT(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .done(done_a),
    .pix_valid(pv_a), .pix_ready(ready_a), .r(r_a), .g(g_a), .b(b_a),
    .raddr(raddr_a), .waddr(waddr_a), .wdata(wdata_a), .wr_enable(we_a)
  );

  sram_pixel_packer #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(2)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .done(done_b),
    .pix_valid(pv_b), .pix_ready(ready_b), .r(r_b), .g(g_b), .b(b_b),
    .raddr(raddr_b), .waddr(waddr_b), .wdata(wdata_b), .wr_enable(we_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [7:0]  r, g, b;
    logic        exp_rdy, exp_we, exp_done;
    logic [17:0] exp_addr;
    logic [15:0] exp_data;
  } vec_t;

  vec_t        tbl [6];
  logic [7:0]  pr [8];
  logic [7:0]  pg [8];
  logic [7:0]  pb [8];
  logic [15:0] exp_w [12];

  function automatic logic [15:0] swp(input logic [15:0] w);
`ifdef SRAM_PIXEL_PACKER_BYTESWAP_EN
    return {w[7:0], w[15:8]};
`else
    return w;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference packer for the 4x2 frame
  task automatic build_frame(input logic [7:0] base);
    for (int i = 0; i < 8; i++) begin
      pr[i] = 8'(base + 8'(i * 3));
      pg[i] = 8'(base + 8'(i * 3 + 1));
      pb[i] = 8'(base + 8'(i * 3 + 2));
    end
    for (int k = 0; k < 4; k++) begin
      exp_w[3*k]   = swp({pr[2*k],   pg[2*k]});
      exp_w[3*k+1] = swp({pb[2*k],   pr[2*k+1]});
      exp_w[3*k+2] = swp({pg[2*k+1], pb[2*k+1]});
    end
  endtask

  // Stream one 4x2 frame into dut_b, checking every cycle against a timing model.
  task automatic run_b(input bit gaps, input int stray_at, input int abort_at);
    int pi = 0, wi = 0, dn = 0, after_done = 0;
    bit acc = 0, acc_p = 0, odd_p = 0, odd_p2 = 0, we_prev = 0, finished = 0;
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      if (abort_at > 0 && pi == abort_at) break;
      chk("b_we", 32'(we_b), 32'(acc_p || odd_p2));
      if (we_b) begin
        if (wi < 12) begin
          chk("b_waddr", 32'(waddr_b), 32'(18'(115200 + wi)));
          chk("b_wdata", 32'(wdata_b), 32'(exp_w[wi]));
        end else begin
          chk("b_extra_write", 32'(wi + 1), 32'd12);
        end
        wi++;
      end
      chk("b_ready", 32'(ready_b), 32'((pi < 8) && !odd_p));
      if (done_b) begin
        dn++;
        chk("b_done_after_last_write", 32'(we_prev && (wi == 12)), 32'd1);
      end
      we_prev = we_b;
      start_b = (cyc == stray_at);
      pv_b = (pi < 8) ? (gaps ? ($urandom_range(0, 2) != 0) : 1'b1) : 1'b0;
      if (pv_b) begin
        r_b = pr[pi]; g_b = pg[pi]; b_b = pb[pi];
      end else begin
        r_b = 8'($urandom); g_b = 8'($urandom); b_b = 8'($urandom);
      end
      acc    = pv_b && ready_b;
      odd_p2 = odd_p;
      odd_p  = acc && pi[0];
      acc_p  = acc;
      if (acc) pi++;
      if (dn > 0) after_done++;
      if (after_done >= 2) finished = 1;
      @(negedge clk);
    end
    start_b = 1'b0;
    if (abort_at == 0) begin
      chk("b_frame_finished", 32'(finished), 32'd1);
      chk("b_write_count", 32'(wi), 32'd12);
      chk("b_done_count", 32'(dn), 32'd1);
    end
  endtask

  initial begin
    clk = 1'b0; reset = 1'b0;
    start_a = 1'b0; pv_a = 1'b1; r_a = 8'h00; g_a = 8'h00; b_a = 8'h00;
    start_b = 1'b0; pv_b = 1'b1; r_b = 8'h00; g_b = 8'h00; b_b = 8'h00;

    tbl[0] = '{1'b1, 8'h11, 8'h22, 8'h33, 1'b1, 1'b0, 1'b0, 18'd0,   16'h0000};
    tbl[1] = '{1'b1, 8'h44, 8'h55, 8'h66, 1'b1, 1'b1, 1'b0, 18'd100, swp(16'h1122)};
    tbl[2] = '{1'b1, 8'h77, 8'h88, 8'h99, 1'b0, 1'b1, 1'b0, 18'd101, swp(16'h3344)};
    tbl[3] = '{1'b1, 8'h77, 8'h88, 8'h99, 1'b0, 1'b1, 1'b0, 18'd102, swp(16'h5566)};
    tbl[4] = '{1'b1, 8'h77, 8'h88, 8'h99, 1'b0, 1'b0, 1'b1, 18'd102, swp(16'h5566)};
    tbl[5] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 18'd102, swp(16'h5566)};

    // Reset and idle: pix_valid high, no start
    repeat (2) @(negedge clk);
    chk("rst_waddr", 32'(waddr_b), 32'd0);
    chk("rst_wdata", 32'(wdata_b), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_ready_a", 32'(ready_a), 32'd0);
      chk("idle_we_a",    32'(we_a),    32'd0);
      chk("idle_done_a",  32'(done_a),  32'd0);
      chk("idle_raddr_a", 32'(raddr_a), 32'd0);
      chk("idle_ready_b", 32'(ready_b), 32'd0);
      chk("idle_we_b",    32'(we_b),    32'd0);
      chk("idle_raddr_b", 32'(raddr_b), 32'd0);
    end
    pv_b = 1'b0;

    // Basic 2x1 pack from the vector table
    start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("a_ready", 32'(ready_a), 32'(tbl[i].exp_rdy));
      chk("a_we",    32'(we_a),    32'(tbl[i].exp_we));
      chk("a_done",  32'(done_a),  32'(tbl[i].exp_done));
      chk("a_waddr", 32'(waddr_a), 32'(tbl[i].exp_addr));
      chk("a_wdata", 32'(wdata_a), 32'(tbl[i].exp_data));
      pv_a = tbl[i].pv; r_a = tbl[i].r; g_a = tbl[i].g; b_a = tbl[i].b;
      @(negedge clk);
    end
    pv_a = 1'b0;

    // 4x2 frame with random gaps and a stray start mid-frame
    build_frame(8'h10);
    run_b(1'b1, 5, 0);
    // 4x2 frame at full rate
    build_frame(8'h80);
    run_b(1'b0, -1, 0);

    // Mid-frame reset after 3 pixels, then a fresh frame
    build_frame(8'h40);
    run_b(1'b0, -1, 3);
    reset = 1'b0; pv_b = 1'b0;
    #1;
    chk("midrst_we",    32'(we_b),    32'd0);
    chk("midrst_ready", 32'(ready_b), 32'd0);
    chk("midrst_waddr", 32'(waddr_b), 32'd0);
    chk("midrst_wdata", 32'(wdata_b), 32'd0);
    chk("midrst_done",  32'(done_b),  32'd0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    chk("post_rst_we", 32'(we_b), 32'd0);
    build_frame(8'hC0);
    run_b(1'b1, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
